// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule controller.
// Holds the key/word types, round constants and the controller FSM encoding.
package aes_pkg;

  typedef logic [127:0] key_128;
  typedef logic [31:0]  aes_word;

  localparam int NR     = 10;
  localparam int NUM_RK = NR + 1;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } state_e;

  // Round constant for round 1..NR; rounds outside that range get 8'h00.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 0; i < NR; i++) begin
      if (int'(rnd) == i + 1) rc = RCON[i];
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_round_key_store.sv
// 11 x 128-bit round-key store: one write port, one registered read port.
// A read and a write to the same entry in one cycle returns the old contents.
module aes_round_key_store
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  key_128     wdata,
  input  logic [3:0] raddr,
  output key_128     rdata
);

  key_128 mem [NUM_RK];

  // NOTE: the array sits in the reset branch on purpose; a reset must wipe every
  // stored round key, so this store maps to flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RK; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && (waddr < 4'(NUM_RK))) mem[waddr] <= wdata;
      rdata <= (raddr < 4'(NUM_RK)) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: sequences an external two-stage key generator
// through ten rounds and collects the eleven round keys into a readable store.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  key_128     key_i,
  output logic       busy,
  output logic       done,
  output logic       keys_valid,
  output logic       kg_en,
  output logic       kg_gen_key,
  output logic       kg_next_rnd,
  output logic [7:0] kg_rcon,
  input  key_128     kg_key,
  input  logic [3:0] rk_idx,
  output key_128     rk_o
);

  state_e     state, state_n;
  logic [3:0] round, round_n;
  logic       phase, phase_n;
  logic       kv_n;
  logic       st_we;
  logic [3:0] st_waddr;
  key_128     st_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      round      <= '0;
      phase      <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      state      <= state_n;
      round      <= round_n;
      phase      <= phase_n;
      keys_valid <= kv_n;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n     = state;
    round_n     = round;
    phase_n     = phase;
    kv_n        = keys_valid;
    busy        = 1'b0;
    done        = 1'b0;
    kg_en       = 1'b0;
    kg_gen_key  = 1'b0;
    kg_next_rnd = 1'b0;
    kg_rcon     = 8'h00;
    st_we       = 1'b0;
    st_waddr    = round;
    st_wdata    = kg_key;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_LOAD;
          round_n  = 4'd1;
          phase_n  = 1'b0;
          kv_n     = 1'b0;
          st_we    = 1'b1;
          st_waddr = 4'd0;
          st_wdata = key_i;
        end
      end
      ST_LOAD: begin
        busy       = 1'b1;
        kg_en      = 1'b1;
        kg_gen_key = 1'b1;
        kg_rcon    = rcon_of(round);
        state_n    = ST_EXPAND;
      end
      ST_EXPAND: begin
        busy        = 1'b1;
        kg_en       = 1'b1;
        kg_gen_key  = 1'b1;
        kg_rcon     = rcon_of(round);
        // Only the very first expand cycle still loads key_i into stage 1.
        kg_next_rnd = (round != 4'd1) || phase;
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          st_we   = 1'b1;
          phase_n = 1'b0;
          if (round == 4'(NR)) begin
            state_n = ST_DONE;
            kv_n    = 1'b1;
          end else begin
            round_n = round + 4'd1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
        round_n = '0;
      end
      default: state_n = ST_IDLE;
    endcase

    // Abort beats everything, including a start seen in the same cycle.
    if (abort) begin
      state_n = ST_IDLE;
      round_n = '0;
      phase_n = 1'b0;
      kv_n    = 1'b0;
      st_we   = 1'b0;
      done    = 1'b0;
    end
  end

  aes_round_key_store u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (rk_idx),
    .rdata (rk_o)
  );

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have start  input  1  request expansion of key_i; sampled only in IDLE.
REQ-004 SHALL have abort  input  1  cancel expansion; accepted in any state.
REQ-005 SHALL have key_i  input  128 (aes_pkg::key_128)  cipher key, held stable by requester during LOAD.
REQ-006 SHALL have busy  output  1  high in LOAD and EXPAND.
REQ-007 SHALL have done  output  1  one-cycle pulse when round key 10 is stored.
REQ-008 SHALL have keys_valid  output  1  high while all 11 stored round keys belong to the last completed expansion.
REQ-009 SHALL have kg_en, kg_gen_key, kg_next_rnd  output  1 each  key-generator pipeline enable, rcon-override select, feedback select.
REQ-010 SHALL have kg_rcon  output  8  round constant for the current round.
REQ-011 SHALL have kg_key  input  128  key-generator round-key output.
REQ-012 SHALL have rk_idx  input  4  round-key read index, 0..10.
REQ-013 SHALL have rk_o  output  128  round-key read data.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, EXPAND, DONE; reset state IDLE.
REQ-015 IDLE: start=1 and abort=0 SHALL go to LOAD, clear keys_valid, write key_i to store[0].
REQ-016 LOAD (1 cycle): SHALL drive kg_en=1, kg_next_rnd=0, kg_gen_key=1, round=1, phase=0; next EXPAND.
REQ-017 EXPAND: each round SHALL take 2 cycles, phase 0 then 1; kg_en=1, kg_gen_key=1 and kg_rcon=RCON[round-1] in both.
REQ-018 kg_next_rnd SHALL be 0 in LOAD and in the first EXPAND cycle, and 1 in all later EXPAND cycles, so stage 1 reloads the fed-back key.
REQ-019 In phase 1, kg_key SHALL be written to store[round]; if round=10 next state DONE, else round increments and phase returns to 0.
REQ-020 DONE (1 cycle): done=1, keys_valid set, kg_en=0; next IDLE.
REQ-021 Latency SHALL be fixed: start sampled at edge T -> LOAD in cycle T+1, EXPAND in cycles T+2..T+21, done high in cycle T+22.
REQ-022 Outside LOAD/EXPAND, kg_en, kg_gen_key and kg_next_rnd SHALL be 0 and kg_rcon SHALL be 8'h00.
REQ-023 RCON SHALL be 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10; round counter 4-bit, never exceeds 10.
REQ-024 start while not IDLE SHALL be ignored; no queuing.
REQ-025 abort SHALL force IDLE on the next edge from any state, clear keys_valid, suppress done, and leave store contents undefined for use.
REQ-026 start and abort both high in IDLE: abort SHALL win; no expansion starts.
REQ-027 rk_o SHALL be registered, 1-cycle read latency; rk_idx>10 SHALL return 128'h0.
REQ-028 Reading any index SHALL be legal at all times; same-cycle write and read of one entry SHALL return the old value.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, round=0, phase=0, busy=0, done=0, keys_valid=0, rk_o=0, all kg_* outputs 0.
REQ-030 Store entries SHALL reset to 0; reset mid-expansion SHALL discard all progress.

Structure
REQ-031 aes_pkg SHALL hold key_128, aes_word, the RCON constant array, NR=10, and the FSM state enum.
REQ-032 The 11x128 store SHALL be one sub-module, aes_round_key_store: one write port, one registered read port.

Verification
REQ-033 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start -> done at T+22; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 Same run: rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=0 -> key_i; rk_idx=15 -> 0.
REQ-035 kg_rcon trace across EXPAND -> each value 01..36 held exactly 2 cycles, in order; kg_next_rnd=0 in LOAD and first EXPAND cycle only.
REQ-036 abort at cycle T+10 -> IDLE at T+11, no done, keys_valid=0; new start -> correct keys.
REQ-037 start pulsed again at T+5 and T+15 -> ignored, done only at T+22; start+abort together in IDLE -> stays IDLE.
REQ-038 rst asserted at T+12 asynchronously -> all outputs 0 before next edge; restart -> REQ-033 values.
